// File: rtl/tpx3_rx_delay_scan.sv
// Input-phase calibration for one Timepix3 serial receiver: sweeps 32 delay taps on both
// DDR edges, scores each by lock/decoder errors and programs the centre of the widest clean window.
module tpx3_rx_delay_scan #(
    parameter int CNT_WIDTH      = 16,
    parameter int DWELL_CYCLES   = 4096,
    parameter int SETTLE_CYCLES  = 64,
    parameter int ERR_RST_CYCLES = 4,
    parameter int MIN_WINDOW     = 4
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST_N,
    input  logic        START,
    input  logic        RX_READY,
    input  logic [7:0]  DECODER_ERR_CNT,
    output logic [4:0]  DLY_VALUE,
    output logic        DLY_LOAD,
    output logic        SAMPLING_EDGE,
    output logic        ERR_RESET,
    output logic        BUSY,
    output logic        DONE,
    output logic        FAIL,
    output logic [5:0]  BEST_LEN,
    output logic [63:0] PASS_MAP,
    output logic [2:0]  DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ERR_CLR = 3'd2,
        S_SETTLE  = 3'd3,
        S_DWELL   = 3'd4,
        S_EVAL    = 3'd5,
        S_APPLY   = 3'd6
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ERR_LAST    = CNT_WIDTH'(ERR_RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DWELL_LAST  = CNT_WIDTH'(DWELL_CYCLES - 1);
    localparam logic [5:0]           MIN_LEN     = 6'(MIN_WINDOW);

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [4:0]           tap_q;
    logic                 edge_q;
    logic                 bad_q;
    logic [5:0]           run_len_q;
    logic [4:0]           run_start_q;
    logic [5:0]           best_len_q;
    logic [4:0]           best_start_q;
    logic                 best_edge_q;

    logic [4:0]  dly_value_q;
    logic        dly_load_q;
    logic        sampling_edge_q;
    logic        err_reset_q;
    logic        busy_q;
    logic        done_q;
    logic        fail_q;
    logic [5:0]  best_len_out_q;
    logic [63:0] pass_map_q;

    logic       pass_d;
    logic [5:0] run_inc_d;
    logic [5:0] run_len_d;
    logic [4:0] run_start_d;
    logic [5:0] best_len_d;
    logic [4:0] best_start_d;
    logic       best_edge_d;
    logic [4:0] centre_d;

    // Window bookkeeping for the setting currently in EVAL; the best-* results
    // feed APPLY directly so the last tap of edge 1 is included.
    always_comb begin
        pass_d       = !bad_q;
        run_inc_d    = run_len_q + 6'd1;
        run_len_d    = 6'd0;
        run_start_d  = run_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        best_edge_d  = best_edge_q;
        if (pass_d) begin
            if (run_len_q == 6'd0) begin
                run_start_d = tap_q;
            end
            run_len_d = run_inc_d;
            if (run_inc_d > best_len_q) begin
                best_len_d   = run_inc_d;
                best_start_d = run_start_d;
                best_edge_d  = edge_q;
            end
        end
        if (tap_q == 5'd31) begin
            run_len_d = 6'd0;
        end
        centre_d = best_start_d + 5'((best_len_d - 6'd1) >> 1);
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            tap_q           <= '0;
            edge_q          <= 1'b0;
            bad_q           <= 1'b0;
            run_len_q       <= '0;
            run_start_q     <= '0;
            best_len_q      <= '0;
            best_start_q    <= '0;
            best_edge_q     <= 1'b0;
            dly_value_q     <= '0;
            dly_load_q      <= 1'b0;
            sampling_edge_q <= 1'b0;
            err_reset_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            fail_q          <= 1'b0;
            best_len_out_q  <= '0;
            pass_map_q      <= '0;
        end else begin
            dly_load_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_q         <= S_LOAD;
                        busy_q          <= 1'b1;
                        done_q          <= 1'b0;
                        fail_q          <= 1'b0;
                        pass_map_q      <= '0;
                        best_len_out_q  <= '0;
                        tap_q           <= '0;
                        edge_q          <= 1'b0;
                        run_len_q       <= '0;
                        run_start_q     <= '0;
                        best_len_q      <= '0;
                        best_start_q    <= '0;
                        best_edge_q     <= 1'b0;
                        dly_value_q     <= '0;
                        sampling_edge_q <= 1'b0;
                        dly_load_q      <= 1'b1;
                        err_reset_q     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= S_ERR_CLR;
                end
                S_ERR_CLR: begin
                    if (cnt_q == ERR_LAST) begin
                        cnt_q       <= '0;
                        err_reset_q <= 1'b0;
                        state_q     <= S_SETTLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        bad_q   <= 1'b0;
                        state_q <= S_DWELL;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                S_DWELL: begin
                    if (!RX_READY || (DECODER_ERR_CNT != 8'd0)) begin
                        bad_q <= 1'b1;
                    end
                    if (cnt_q == DWELL_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_EVAL;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                S_EVAL: begin
                    pass_map_q[{edge_q, tap_q}] <= pass_d;
                    run_len_q    <= run_len_d;
                    run_start_q  <= run_start_d;
                    best_len_q   <= best_len_d;
                    best_start_q <= best_start_d;
                    best_edge_q  <= best_edge_d;
                    dly_load_q   <= 1'b1;
                    err_reset_q  <= 1'b1;
                    if (tap_q != 5'd31) begin
                        tap_q           <= tap_q + 5'd1;
                        dly_value_q     <= tap_q + 5'd1;
                        sampling_edge_q <= edge_q;
                        state_q         <= S_LOAD;
                    end else if (!edge_q) begin
                        edge_q          <= 1'b1;
                        tap_q           <= '0;
                        dly_value_q     <= '0;
                        sampling_edge_q <= 1'b1;
                        state_q         <= S_LOAD;
                    end else begin
                        best_len_out_q <= best_len_d;
                        state_q        <= S_APPLY;
                        if (best_len_d >= MIN_LEN) begin
                            dly_value_q     <= centre_d;
                            sampling_edge_q <= best_edge_d;
                            done_q          <= 1'b1;
                        end else begin
                            dly_value_q     <= '0;
                            sampling_edge_q <= 1'b0;
                            fail_q          <= 1'b1;
                        end
                    end
                end
                S_APPLY: begin
                    busy_q      <= 1'b0;
                    err_reset_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign DLY_VALUE     = dly_value_q;
    assign DLY_LOAD      = dly_load_q;
    assign SAMPLING_EDGE = sampling_edge_q;
    assign ERR_RESET     = err_reset_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign FAIL          = fail_q;
    assign BEST_LEN      = best_len_out_q;
    assign PASS_MAP      = pass_map_q;
    assign DBG_STATE     = state_q;

endmodule
